nios_system_nios2_qsys_0_cpu_ocimem_arbiter: RTL and testbench

Arbitrates the single-port 256x32 on-chip debug RAM (OCIMEM) between two requesters. One is the JTAG debug-slave command path (take_action_ocimem_a/b with jdo). The other is the CPU-side Avalon debug slave. Sequences each access through a small FSM using round-robin arbitration. Returns JTAG read data on MonDReg/monitor_ready and Avalon read data via waitrequest handshake.

---
 rtl/nios_system_nios2_qsys_0_cpu_ocimem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_nios_system_nios2_qsys_0_cpu_ocimem_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_nios2_qsys_0_cpu_ocimem_arbiter.sv
// rtl/nios_system_nios2_qsys_0_cpu_ocimem_arbiter.sv - OCIMEM JTAG/Avalon round-robin arbiter, optional OCIMEM_JTAG_AUTOINC_EN
module nios_system_nios2_qsys_0_cpu_ocimem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [37:0]       jdo,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              jtag_overrun,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [DATA_W-1:0] av_writedata,
    input  logic [3:0]        av_byteenable,
    input  logic              av_debugaccess,
    output logic [DATA_W-1:0] av_readdata,
    output logic              av_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [3:0]        ram_byteen,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_AV_RA = 3'd1;
    localparam logic [2:0] S_AV_RD = 3'd2;
    localparam logic [2:0] S_AV_WR = 3'd3;
    localparam logic [2:0] S_J_RA  = 3'd4;
    localparam logic [2:0] S_J_RD  = 3'd5;
    localparam logic [2:0] S_J_WR  = 3'd6;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic              jtag_pend;
    logic              jtag_rd;
    logic [ADDR_W-1:0] jptr;
    logic [DATA_W-1:0] jwdata;
    logic              last_grant_jtag;

    // Bits of jdo that carry nothing for OCIMEM commands.
    logic unused_jdo;
    assign unused_jdo = ^{jdo[37], jdo[2:0]};

    // A JTAG command arriving this cycle is visible to the arbiter immediately,
    // so a free resource starts serving it without waiting for the capture flop.
    logic              j_new_rd;
    logic              j_new;
    logic              j_accept;
    logic              j_drop;
    logic              j_ptr_load;
    logic              j_pend_eff;
    logic              j_rd_eff;
    logic [ADDR_W-1:0] jptr_eff;
    logic              av_req;
    logic              grant_j;
    logic              grant_av;
    logic              tie;
    logic              j_done;

    assign j_new_rd   = take_action_ocimem_a & jdo[35];
    assign j_new      = j_new_rd | take_action_ocimem_b;
    assign j_accept   = j_new & ~jtag_pend;
    assign j_drop     = j_new & jtag_pend;
    assign j_ptr_load = take_action_ocimem_a & ~jtag_pend;
    assign j_pend_eff = jtag_pend | j_accept;
    assign j_rd_eff   = jtag_pend ? jtag_rd : j_new_rd;
    assign jptr_eff   = j_ptr_load ? jdo[33:26] : jptr;

    // Simultaneous read and write from Avalon is served as a read.
    assign av_req   = av_read | av_write;
    assign tie      = j_pend_eff & av_req;
    assign grant_j  = j_pend_eff & (~av_req | ~last_grant_jtag);
    assign grant_av = av_req & ~grant_j;
    assign j_done   = (state == S_J_RD) | (state == S_J_WR);

    // Next-state sequencing of one access at a time.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (grant_j) begin
                    state_nxt = j_rd_eff ? S_J_RA : S_J_WR;
                end else if (grant_av) begin
                    state_nxt = av_read ? S_AV_RA : S_AV_WR;
                end
            end
            S_AV_RA: state_nxt = S_AV_RD;
            S_AV_RD: state_nxt = S_IDLE;
            S_AV_WR: state_nxt = S_IDLE;
            S_J_RA:  state_nxt = S_J_RD;
            S_J_RD:  state_nxt = S_IDLE;
            S_J_WR:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, round-robin history and RAM address, loaded when a grant is made.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            last_grant_jtag <= 1'b0;
            ram_addr        <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE) begin
                if (tie) begin
                    last_grant_jtag <= grant_j;
                end
                if (grant_j) begin
                    ram_addr <= jptr_eff;
                end else if (grant_av) begin
                    ram_addr <= av_address;
                end
            end
        end
    end

    // JTAG command capture, single-entry pending slot and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            jtag_pend    <= 1'b0;
            jtag_rd      <= 1'b0;
            jptr         <= '0;
            jwdata       <= '0;
            jtag_overrun <= 1'b0;
        end else begin
            if (j_done) begin
                jtag_pend <= 1'b0;
`ifdef OCIMEM_JTAG_AUTOINC_EN
                jptr <= jptr + 1'b1;
`endif
            end
            if (j_accept) begin
                jtag_pend <= 1'b1;
                jtag_rd   <= j_new_rd;
            end
            if (j_ptr_load) begin
                jptr <= jdo[33:26];
            end
            if (take_action_ocimem_b & ~jtag_pend) begin
                jwdata <= jdo[34:3];
            end
            if (take_action_ocimem_a & jdo[36]) begin
                jtag_overrun <= 1'b0;
            end
            if (j_drop) begin
                jtag_overrun <= 1'b1;
            end
        end
    end

    // JTAG read data return; monitor_ready marks the cycle MonDReg is fresh.
    always_ff @(posedge clk) begin
        if (reset) begin
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
        end else begin
            monitor_ready <= (state == S_J_RD);
            if (state == S_J_RD) begin
                MonDReg <= ram_rdata;
            end
        end
    end

    assign av_waitrequest = ~((state == S_AV_RD) | (state == S_AV_WR));
    assign av_readdata    = ram_rdata;
    assign ram_wren       = (state == S_J_WR) | ((state == S_AV_WR) & av_debugaccess);
    assign ram_byteen     = (state == S_J_WR) ? 4'hF : av_byteenable;
    assign ram_wdata      = (state == S_J_WR) ? jwdata : av_writedata;

endmodule

// File: tb/tb_nios_system_nios2_qsys_0_cpu_ocimem_arbiter.sv
// tb/tb_nios_system_nios2_qsys_0_cpu_ocimem_arbiter.sv - scoreboard bench for the OCIMEM arbiter
module tb_nios_system_nios2_qsys_0_cpu_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic [37:0] jdo;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        jtag_overrun;
    logic [7:0]  av_address;
    logic        av_read;
    logic        av_write;
    logic [31:0] av_writedata;
    logic [3:0]  av_byteenable;
    logic        av_debugaccess;
    logic [31:0] av_readdata;
    logic        av_waitrequest;
    logic [7:0]  ram_addr;
    logic        ram_wren;
    logic [3:0]  ram_byteen;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    always #5 clk = ~clk;

    nios_system_nios2_qsys_0_cpu_ocimem_arbiter dut (
        .clk(clk), .reset(reset),
        .take_action_ocimem_a(take_action_ocimem_a), .take_action_ocimem_b(take_action_ocimem_b),
        .jdo(jdo), .MonDReg(MonDReg), .monitor_ready(monitor_ready), .jtag_overrun(jtag_overrun),
        .av_address(av_address), .av_read(av_read), .av_write(av_write),
        .av_writedata(av_writedata), .av_byteenable(av_byteenable), .av_debugaccess(av_debugaccess),
        .av_readdata(av_readdata), .av_waitrequest(av_waitrequest),
        .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_byteen(ram_byteen),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

`ifdef OCIMEM_JTAG_AUTOINC_EN
    localparam logic [7:0] WRAP_ADDR = 8'h00;
`else
    localparam logic [7:0] WRAP_ADDR = 8'hFF;
`endif

    function automatic logic [31:0] pat(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++) if (be[b]) old[8*b +: 8] = d[8*b +: 8];
        return old;
    endfunction

    // OCIMEM: 256x32, byte-enabled writes, registered read data.
    logic [31:0] ram [256];
    bit          tb_init;
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= pat(i);
        end else if (ram_wren) begin
            for (int b = 0; b < 4; b++) if (ram_byteen[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
        ram_rdata <= ram[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [7:0] a; logic [3:0] be; logic [31:0] d; int cyc; } wr_t;
    typedef struct { logic rd; logic [31:0] d; int cyc; } rsp_t;
    wr_t  wr_q[$];
    rsp_t av_q[$];
    rsp_t mon_q[$];
    wr_t  we;
    rsp_t re;

    logic [31:0] ref_mem [256];
    bit          tie_j;
    bit          mon_en = 1'b0;
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: event not expected or missing (cycle %0d)", name, cyc);
    endtask

    // Monitor: every DUT output event is matched against the oldest expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ram_wren) begin
                if (wr_q.size() == 0) fail("ram_wren_unexpected");
                else begin
                    we = wr_q.pop_front();
                    chk("ram_write", {ram_addr, ram_byteen, ram_wdata}, {we.a, we.be, we.d});
                    if (we.cyc >= 0) chk("ram_write_cycle", 64'(cyc), 64'(we.cyc));
                end
            end
            if (!av_waitrequest) begin
                if (av_q.size() == 0) fail("av_accept_unexpected");
                else begin
                    re = av_q.pop_front();
                    if (re.rd) chk("av_readdata", av_readdata, re.d);
                    if (re.cyc >= 0) chk("av_accept_cycle", 64'(cyc), 64'(re.cyc));
                end
            end
            if (monitor_ready) begin
                if (mon_q.size() == 0) fail("monitor_ready_unexpected");
                else begin
                    re = mon_q.pop_front();
                    chk("MonDReg", MonDReg, re.d);
                    if (re.cyc >= 0) chk("monitor_ready_cycle", 64'(cyc), 64'(re.cyc));
                end
            end
        end
    end

    // Reference: an Avalon access started at 'start' in a free arbiter.
    task automatic exp_av(input bit rd, input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                          input bit dbg, input int start, output int len);
        rsp_t r;
        wr_t  w;
        r.rd = rd;
        r.d  = rd ? ref_mem[a] : 32'h0;
        r.cyc = rd ? start + 2 : start + 1;
        av_q.push_back(r);
        if (!rd && dbg) begin
            w.a = a; w.be = be; w.d = d; w.cyc = start + 1;
            wr_q.push_back(w);
            ref_mem[a] = merge(ref_mem[a], d, be);
        end
        len = rd ? 3 : 2;
    endtask

    // Reference: a JTAG access whose service starts at 'start'.
    task automatic exp_j(input bit rd, input logic [7:0] a, input logic [31:0] d, input int start, output int len);
        rsp_t r;
        wr_t  w;
        if (rd) begin
            r.rd = 1'b1; r.d = ref_mem[a]; r.cyc = start + 3;
            mon_q.push_back(r);
            len = 3;
        end else begin
            w.a = a; w.be = 4'hF; w.d = d; w.cyc = start + 1;
            wr_q.push_back(w);
            ref_mem[a] = d;
            len = 2;
        end
    endtask

    task automatic jtag_a(input logic [7:0] a, input bit rd, input bit clr);
        jdo = '0;
        jdo[33:26] = a;
        jdo[35] = rd;
        jdo[36] = clr;
        take_action_ocimem_a = 1'b1;
        @(posedge clk); #1;
        take_action_ocimem_a = 1'b0;
    endtask

    task automatic jtag_b(input logic [31:0] d);
        jdo = '0;
        jdo[34:3] = d;
        take_action_ocimem_b = 1'b1;
        @(posedge clk); #1;
        take_action_ocimem_b = 1'b0;
    endtask

    task automatic av_xfer(input bit rd, input logic [7:0] a, input logic [31:0] d, input logic [3:0] be, input bit dbg);
        bit done = 1'b0;
        av_address = a; av_read = rd; av_write = !rd;
        av_writedata = d; av_byteenable = be; av_debugaccess = dbg;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!av_waitrequest) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) fail("av_waitrequest_timeout");
        @(posedge clk); #1;
        av_read = 1'b0;
        av_write = 1'b0;
    endtask

    task automatic drain();
        bit empty = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (wr_q.size() == 0 && av_q.size() == 0 && mon_q.size() == 0) begin
                empty = 1'b1;
                break;
            end
            @(posedge clk);
        end
        if (!empty) begin
            fail("drain_timeout");
            wr_q.delete(); av_q.delete(); mon_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tie_j = 1'b1;
    endtask

    // Both requesters start in the same cycle; the tie winner is served first.
    task automatic tie(input bit jrd, input logic [7:0] ja, input logic [31:0] jd,
                       input bit ard, input logic [7:0] aa, input logic [31:0] ad,
                       input logic [3:0] abe, input bit adbg);
        int c;
        int l1;
        int l2;
        if (!jrd) jtag_a(ja, 1'b0, 1'b0);
        c = cyc;
        if (tie_j) begin
            exp_j(jrd, ja, jd, c, l1);
            exp_av(ard, aa, ad, abe, adbg, c + l1, l2);
        end else begin
            exp_av(ard, aa, ad, abe, adbg, c, l1);
            exp_j(jrd, ja, jd, c + l1, l2);
        end
        tie_j = !tie_j;
        fork
            av_xfer(ard, aa, ad, abe, adbg);
            begin
                if (jrd) jtag_a(ja, 1'b1, 1'b0);
                else jtag_b(jd);
            end
        join
        drain();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        int len;
        bit rd;
        bit jrd;
        logic [7:0] a;
        logic [7:0] a2;
        logic [31:0] d;
        reset = 1'b1;
        take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; jdo = '0;
        av_address = '0; av_read = 1'b0; av_write = 1'b0; av_writedata = '0;
        av_byteenable = '0; av_debugaccess = 1'b0;
        tie_j = 1'b1;
        tb_init = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        @(posedge clk); #1 tb_init = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_MonDReg", MonDReg, 0);
        chk("rst_monitor_ready", monitor_ready, 0);
        chk("rst_jtag_overrun", jtag_overrun, 0);
        chk("rst_av_waitrequest", av_waitrequest, 1);
        chk("rst_ram_wren", ram_wren, 0);
        chk("rst_ram_addr", ram_addr, 0);
        @(posedge clk); #1 reset = 1'b0;
        mon_en = 1'b1;

        // JTAG write of DEADBEEF to 0x10, then read it back over JTAG.
        jtag_a(8'h10, 1'b0, 1'b0);
        c = cyc; exp_j(1'b0, 8'h10, 32'hDEADBEEF, c, len);
        jtag_b(32'hDEADBEEF);
        drain();
        c = cyc; exp_j(1'b1, 8'h10, 32'h0, c, len);
        jtag_a(8'h10, 1'b1, 1'b0);
        drain();

        // Avalon read, discarded write, read-back, byte-enabled write.
        c = cyc; exp_av(1'b1, 8'h10, 32'h0, 4'h0, 1'b1, c, len);
        av_xfer(1'b1, 8'h10, 32'h0, 4'h0, 1'b1);
        drain();
        c = cyc; exp_av(1'b0, 8'h10, 32'h12345678, 4'hF, 1'b0, c, len);
        av_xfer(1'b0, 8'h10, 32'h12345678, 4'hF, 1'b0);
        drain();
        c = cyc; exp_av(1'b1, 8'h10, 32'h0, 4'h0, 1'b1, c, len);
        av_xfer(1'b1, 8'h10, 32'h0, 4'h0, 1'b1);
        drain();
        c = cyc; exp_av(1'b0, 8'h20, 32'hA5A5A5A5, 4'b0101, 1'b1, c, len);
        av_xfer(1'b0, 8'h20, 32'hA5A5A5A5, 4'b0101, 1'b1);
        drain();
        c = cyc; exp_j(1'b1, 8'h20, 32'h0, c, len);
        jtag_a(8'h20, 1'b1, 1'b0);
        drain();

        // Simultaneous reads after reset: JTAG first, then alternating.
        do_reset();
        for (int r = 0; r < 4; r++) tie(1'b1, 8'(r), 32'h0, 1'b1, 8'(8'h40 + r), 32'h0, 4'h0, 1'b1);

        // Second action_b while the first is still pending is dropped.
        jtag_a(8'h30, 1'b0, 1'b0);
        c = cyc;
        exp_av(1'b1, 8'h10, 32'h0, 4'h0, 1'b1, c, len);
        exp_j(1'b0, 8'h30, 32'h11110001, c + 3, len);
        fork
            av_xfer(1'b1, 8'h10, 32'h0, 4'h0, 1'b1);
            begin
                @(posedge clk); #1;
                jtag_b(32'h11110001);
                jtag_b(32'h22220002);
            end
        join
        drain();
        @(negedge clk);
        chk("overrun_set", jtag_overrun, 1);
        @(posedge clk); #1;
        jtag_a(8'h30, 1'b0, 1'b1);
        @(negedge clk);
        chk("overrun_clear", jtag_overrun, 0);
        @(posedge clk); #1;
        c = cyc; exp_j(1'b1, 8'h30, 32'h0, c, len);
        jtag_a(8'h30, 1'b1, 1'b0);
        drain();

        // Pointer at 0xFF followed by two writes.
        jtag_a(8'hFF, 1'b0, 1'b0);
        c = cyc; exp_j(1'b0, 8'hFF, 32'hCAFE0001, c, len);
        jtag_b(32'hCAFE0001);
        drain();
        c = cyc; exp_j(1'b0, WRAP_ADDR, 32'hCAFE0002, c, len);
        jtag_b(32'hCAFE0002);
        drain();

        // Randomised traffic: single requesters and ties.
        for (int it = 0; it < 60; it++) begin
            a  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            a2 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            d  = $urandom;
            rd  = 1'($urandom_range(0, 1));
            jrd = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: begin
                    logic [3:0] be;
                    bit dbg;
                    be = 4'($urandom);
                    dbg = ($urandom_range(0, 3) != 0);
                    c = cyc; exp_av(rd, a, d, be, dbg, c, len);
                    av_xfer(rd, a, d, be, dbg);
                    drain();
                end
                1: begin
                    if (jrd) begin
                        c = cyc; exp_j(1'b1, a, 32'h0, c, len);
                        jtag_a(a, 1'b1, 1'b0);
                    end else begin
                        jtag_a(a, 1'b0, 1'b0);
                        c = cyc; exp_j(1'b0, a, d, c, len);
                        jtag_b(d);
                    end
                    drain();
                end
                default: tie(jrd, a, $urandom, rd, a2, d, 4'($urandom), ($urandom_range(0, 3) != 0));
            endcase
        end

        // Reset while the Avalon read sits in its address cycle.
        c = cyc;
        re.rd = 1'b1; re.d = ref_mem[8'h33]; re.cyc = c + 5;
        av_q.push_back(re);
        fork
            av_xfer(1'b1, 8'h33, 32'h0, 4'h0, 1'b1);
            begin
                @(posedge clk); #1 reset = 1'b1;
                @(negedge clk);
                chk("rstmid_waitrequest_a", av_waitrequest, 1);
                @(posedge clk); #1;
                @(negedge clk);
                chk("rstmid_waitrequest_b", av_waitrequest, 1);
                chk("rstmid_MonDReg", MonDReg, 0);
                chk("rstmid_monitor_ready", monitor_ready, 0);
                chk("rstmid_ram_addr", ram_addr, 0);
                @(posedge clk); #1 reset = 1'b0;
                tie_j = 1'b1;
            end
        join
        drain();

        chk("queues_empty", 64'(wr_q.size() + av_q.size() + mon_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
